// File: rtl/wb_pkg.sv
// Shared encodings for the writeback/commit stage: result selects, load
// funct3 codes and the commit FSM state type.
package wb_pkg;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_PC4  = 2'd2;
    localparam logic [1:0] WB_SEL_NONE = 2'd3;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load extraction: picks the byte/half lane from the aligned
// memory word and sign/zero-extends it. Build with WB_MISALIGN_TRAP_EN to
// also get the misalignment flag.
module load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
`ifdef WB_MISALIGN_TRAP_EN
    output logic            misaligned,
`endif
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half lane ignores offset[0]; a misaligned LH without the trap simply
    // reads the half it falls inside.
    always_comb begin
        case (offset)
            2'd0:    byte_lane = word[7:0];
            2'd1:    byte_lane = word[15:8];
            2'd2:    byte_lane = word[23:16];
            default: byte_lane = word[31:24];
        endcase
        half_lane = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            default: data = word;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    // Reserved funct3 codes behave as LW, so they share its alignment rule.
    always_comb begin
        case (funct3)
            F3_LB, F3_LBU: misaligned = 1'b0;
            F3_LH, F3_LHU: misaligned = offset[0];
            default:       misaligned = (offset != 2'd0);
        endcase
    end
`endif

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: selects ALU / load / PC+4 results, waits for load
// data and drives the register-file write port from registered outputs.
// Optional feature macro: WB_MISALIGN_TRAP_EN (adds misalign_err).
module wb_commit
    import wb_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rd,
    input  logic [1:0]      in_wb_sel,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_pc,
    input  logic [2:0]      in_funct3,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    output logic [RA_W-1:0] addr_rd,
    output logic [XLEN-1:0] data_rd,
    output logic            write_enable,
`ifdef WB_MISALIGN_TRAP_EN
    output logic            misalign_err,
`endif
    output logic            pend_valid,
    output logic [RA_W-1:0] pend_rd
);

    wb_state_e       state, state_next;
    logic [2:0]      ld_funct3, ld_funct3_next;
    logic [1:0]      ld_offset, ld_offset_next;
    logic [RA_W-1:0] addr_next, pend_rd_next;
    logic [XLEN-1:0] data_next, align_data;
    logic            we_next, pend_valid_next;
`ifdef WB_MISALIGN_TRAP_EN
    logic            align_misaligned, err_next;
`endif

    load_align #(.XLEN(XLEN)) u_align (
        .word       (mem_rsp_data),
        .offset     (ld_offset),
        .funct3     (ld_funct3),
`ifdef WB_MISALIGN_TRAP_EN
        .misaligned (align_misaligned),
`endif
        .data       (align_data)
    );

    // Response cycle keeps in_ready low, so the next accept lands one cycle later.
    assign in_ready = (state == IDLE);

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_next      = state;
        we_next         = 1'b0;
        addr_next       = addr_rd;
        data_next       = data_rd;
        pend_valid_next = pend_valid;
        pend_rd_next    = pend_rd;
        ld_funct3_next  = ld_funct3;
        ld_offset_next  = ld_offset;
`ifdef WB_MISALIGN_TRAP_EN
        err_next        = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (in_valid) begin
                    case (in_wb_sel)
                        WB_SEL_ALU: begin
                            addr_next = in_rd;
                            data_next = in_alu_result;
                            we_next   = (in_rd != '0);
                        end
                        WB_SEL_PC4: begin
                            addr_next = in_rd;
                            data_next = in_pc + XLEN'(4);
                            we_next   = (in_rd != '0);
                        end
                        WB_SEL_LOAD: begin
                            state_next      = WAIT_MEM;
                            pend_valid_next = 1'b1;
                            pend_rd_next    = in_rd;
                            ld_funct3_next  = in_funct3;
                            ld_offset_next  = in_alu_result[1:0];
                        end
                        default: ;
                    endcase
                end
            end
            WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    state_next      = IDLE;
                    pend_valid_next = 1'b0;
                    addr_next       = pend_rd;
                    data_next       = align_data;
`ifdef WB_MISALIGN_TRAP_EN
                    err_next        = align_misaligned;
                    we_next         = (pend_rd != '0) && !align_misaligned;
`else
                    we_next         = (pend_rd != '0);
`endif
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            write_enable <= 1'b0;
            addr_rd      <= '0;
            data_rd      <= '0;
            pend_valid   <= 1'b0;
            pend_rd      <= '0;
            ld_funct3    <= '0;
            ld_offset    <= '0;
`ifdef WB_MISALIGN_TRAP_EN
            misalign_err <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            write_enable <= we_next;
            addr_rd      <= addr_next;
            data_rd      <= data_next;
            pend_valid   <= pend_valid_next;
            pend_rd      <= pend_rd_next;
            ld_funct3    <= ld_funct3_next;
            ld_offset    <= ld_offset_next;
`ifdef WB_MISALIGN_TRAP_EN
            misalign_err <= err_next;
`endif
        end
    end

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: ALU/PC4 commits, load extraction, stall,
// reset mid-load, stray responses and (with WB_MISALIGN_TRAP_EN) the trap.
`timescale 1ns/1ps
module tb_wb_commit;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic [1:0]  in_wb_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc;
    logic [2:0]  in_funct3;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  addr_rd;
    logic [31:0] data_rd;
    logic        write_enable;
    logic        pend_valid;
    logic [4:0]  pend_rd;
`ifdef WB_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_commit #(.XLEN(32), .RA_W(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .in_funct3     (in_funct3),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .addr_rd       (addr_rd),
        .data_rd       (data_rd),
        .write_enable  (write_enable),
`ifdef WB_MISALIGN_TRAP_EN
        .misalign_err  (misalign_err),
`endif
        .pend_valid    (pend_valid),
        .pend_rd       (pend_rd)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for checks
    // and new inputs are set up well before the following edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [4:0] rd,
                         input logic [31:0] alu, input logic [31:0] pc,
                         input logic [2:0] f3);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd         = rd;
        in_alu_result = alu;
        in_pc         = pc;
        in_funct3     = f3;
    endtask

    // One-cycle-response load: accept, one wait cycle, response, then check.
    task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] word,
                           input logic [31:0] exp);
        drive(WB_SEL_LOAD, rd, addr, 32'h0, f3);
        tick();
        in_valid = 1'b0;
        check({tag, "_pend_valid"}, 32'(pend_valid), 32'd1);
        check({tag, "_pend_rd"}, 32'(pend_rd), 32'(rd));
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = word;
        tick();
        mem_rsp_valid = 1'b0;
        check({tag, "_we"}, 32'(write_enable), 32'd1);
        check({tag, "_addr"}, 32'(addr_rd), 32'(rd));
        check({tag, "_data"}, data_rd, exp);
        check({tag, "_pend_clr"}, 32'(pend_valid), 32'd0);
        tick();
        check({tag, "_we_drop"}, 32'(write_enable), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_rd         = '0;
        in_wb_sel     = WB_SEL_NONE;
        in_alu_result = '0;
        in_pc         = '0;
        in_funct3     = '0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        tick();
        tick();
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_addr", 32'(addr_rd), 32'd0);
        check("rst_data", data_rd, 32'd0);
        check("rst_pend_valid", 32'(pend_valid), 32'd0);
        check("rst_pend_rd", 32'(pend_rd), 32'd0);
`ifdef WB_MISALIGN_TRAP_EN
        check("rst_misalign", 32'(misalign_err), 32'd0);
`endif
        reset = 1'b0;

        // ALU commit, latency 1, single-cycle pulse
        drive(WB_SEL_ALU, 5'd5, 32'hDEADBEEF, 32'h0, 3'd0);
        tick();
        in_valid = 1'b0;
        check("alu_we", 32'(write_enable), 32'd1);
        check("alu_addr", 32'(addr_rd), 32'd5);
        check("alu_data", data_rd, 32'hDEADBEEF);
        tick();
        check("alu_we_drop", 32'(write_enable), 32'd0);

        // PC4 wraps, then back-to-back ALU to x0 is suppressed
        drive(WB_SEL_PC4, 5'd1, 32'h0, 32'hFFFFFFFC, 3'd0);
        tick();
        drive(WB_SEL_ALU, 5'd0, 32'h00001234, 32'h0, 3'd0);
        check("pc4_we", 32'(write_enable), 32'd1);
        check("pc4_addr", 32'(addr_rd), 32'd1);
        check("pc4_data", data_rd, 32'h00000000);
        tick();
        in_valid = 1'b0;
        check("x0_we", 32'(write_enable), 32'd0);

        // wb_sel NONE completes without writing and leaves the stage ready
        drive(WB_SEL_NONE, 5'd4, 32'h55, 32'h0, 3'd0);
        tick();
        in_valid = 1'b0;
        check("none_we", 32'(write_enable), 32'd0);
        check("none_ready", 32'(in_ready), 32'd1);

        // Load extraction
        do_load("lb",  5'd7,  F3_LB,  32'h1003, 32'h80112233, 32'hFFFFFF80);
        do_load("lbu", 5'd8,  F3_LBU, 32'h1003, 32'h80112233, 32'h00000080);
        do_load("lhu", 5'd11, F3_LHU, 32'h2002, 32'hBEEF0000, 32'h0000BEEF);
        do_load("lh",  5'd12, F3_LH,  32'h2002, 32'h80017FFF, 32'hFFFF8001);
        do_load("lb1", 5'd13, F3_LB,  32'h2001, 32'h00007F00, 32'h0000007F);
        do_load("lw",  5'd14, F3_LW,  32'h2000, 32'hCAFEF00D, 32'hCAFEF00D);
`ifndef WB_MISALIGN_TRAP_EN
        do_load("lh_mis", 5'd15, F3_LH, 32'h2001, 32'h12348765, 32'hFFFF8765);
        do_load("lw_mis", 5'd16, F3_LW, 32'h2002, 32'h0BADCAFE, 32'h0BADCAFE);
`endif

        // Load stall: response three cycles after accept, ALU held valid
        drive(WB_SEL_LOAD, 5'd9, 32'h00000100, 32'h0, F3_LW);
        tick();
        drive(WB_SEL_ALU, 5'd10, 32'h0000A5A5, 32'h0, 3'd0);
        check("stall_ready_n1", 32'(in_ready), 32'd0);
        tick();
        check("stall_ready_n2", 32'(in_ready), 32'd0);
        check("stall_we_n2", 32'(write_enable), 32'd0);
        tick();
        check("stall_ready_n3", 32'(in_ready), 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h12345678;
        tick();
        mem_rsp_valid = 1'b0;
        check("stall_ld_we", 32'(write_enable), 32'd1);
        check("stall_ld_addr", 32'(addr_rd), 32'd9);
        check("stall_ld_data", data_rd, 32'h12345678);
        check("stall_ready_n4", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("stall_alu_we", 32'(write_enable), 32'd1);
        check("stall_alu_addr", 32'(addr_rd), 32'd10);
        check("stall_alu_data", data_rd, 32'h0000A5A5);
        tick();
        check("stall_we_drop", 32'(write_enable), 32'd0);

        // Reset mid-load, then a late response is ignored
        drive(WB_SEL_LOAD, 5'd3, 32'h0, 32'h0, F3_LW);
        tick();
        in_valid = 1'b0;
        check("rml_pend", 32'(pend_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset         = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFFFFFF;
        check("rml_pend_clr", 32'(pend_valid), 32'd0);
        check("rml_ready", 32'(in_ready), 32'd1);
        check("rml_we", 32'(write_enable), 32'd0);
        tick();
        mem_rsp_valid = 1'b0;
        check("rml_late_we", 32'(write_enable), 32'd0);
        check("rml_late_pend", 32'(pend_valid), 32'd0);

        // Stray response while idle
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'h11111111;
        tick();
        mem_rsp_valid = 1'b0;
        check("stray_we", 32'(write_enable), 32'd0);
        check("stray_ready", 32'(in_ready), 32'd1);

`ifdef WB_MISALIGN_TRAP_EN
        // Misaligned LW traps instead of writing
        drive(WB_SEL_LOAD, 5'd6, 32'h00000302, 32'h0, F3_LW);
        tick();
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hAAAA5555;
        tick();
        mem_rsp_valid = 1'b0;
        check("mis_err", 32'(misalign_err), 32'd1);
        check("mis_we", 32'(write_enable), 32'd0);
        check("mis_pend_clr", 32'(pend_valid), 32'd0);
        tick();
        check("mis_err_drop", 32'(misalign_err), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
